// File: rtl/mul_seq_pkg.sv
// Shared constants for the multicycle multiplier and its ALU.
// Holds the ALU opcodes and the sequencer state encodings.
package mul_seq_pkg;

    localparam int DW = 32;
    localparam int CW = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } ms_state_t;

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU shared by the datapath.
// zout flags an all-zero result.
module alu
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DW
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zout
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: y = {{(WIDTH-1){1'b0}}, a < b};
            default: y = '0;
        endcase
    end

    assign zout = (y == '0);

endmodule

// File: rtl/mul_seq.sv
// Shift-add multiplier sequencer; low 32 bits of a*b using the ALU.
// One multiplier bit per RUN cycle, stopping at the top set bit.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             zero
);

    ms_state_t        state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] step;
    logic             unused_zout;

    alu #(.WIDTH(WIDTH)) u_alu (
        .op   (OP_ADD),
        .a    (acc_q),
        .b    (mcand_q),
        .y    (alu_y),
        .zout (unused_zout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MS_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            prod_q   <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            prod_q   <= prod_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        prod_d   = prod_q;
        zero_d   = zero_q;
        step     = acc_q;
        unique case (state_q)
            MS_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = '0;
                    if (b == '0) begin
                        prod_d  = '0;
                        zero_d  = 1'b1;
                        state_d = MS_DONE;
                    end else begin
                        state_d = MS_RUN;
                    end
                end
            end
            MS_RUN: begin
                step     = mplier_q[0] ? alu_y : acc_q;
                acc_d    = step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                // stop once no set bits remain above the one just consumed
                if (mplier_d == '0 || count_q == 5'd31) begin
                    prod_d  = step;
                    zero_d  = (step == '0);
                    state_d = MS_DONE;
                end
            end
            MS_DONE: state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    assign busy    = (state_q != MS_IDLE);
    assign done    = (state_q == MS_DONE);
    assign product = prod_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed vectors plus random jobs
// checked against plain a*b and the top-set-bit latency rule.
module tb_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        zero;

    int checks;
    int failures;

    mul_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nbits(input logic [31:0] v);
        for (int i = 31; i >= 0; i--)
            if (v[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint unsigned p;
        p = longint'(x) * longint'(y);
        return p[31:0];
    endfunction

    // Drives one job from an IDLE negedge; measures edges to done.
    task automatic do_job(input logic [31:0] ja, input logic [31:0] jb,
                          output int edges, output logic b1,
                          output logic [31:0] p, output logic z,
                          output logic after);
        a = ja;
        b = jb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        edges = 1;
        b1 = busy;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        p = product;
        z = zero;
        @(negedge clk);
        after = busy | done;
    endtask

    task automatic check_job(input string tag, input logic [31:0] ja,
                             input logic [31:0] jb);
        int          edges;
        logic        b1, z, after;
        logic [31:0] p, ep;
        int          ee;
        do_job(ja, jb, edges, b1, p, z, after);
        ep = ref_mul(ja, jb);
        ee = nbits(jb) + 1;
        checks++;
        if (edges !== ee) begin
            failures++;
            $display("FAIL %s latency a=%h b=%h got %0d want %0d", tag, ja, jb, edges, ee);
        end
        checks++;
        if (p !== ep) begin
            failures++;
            $display("FAIL %s product a=%h b=%h got %h want %h", tag, ja, jb, p, ep);
        end
        checks++;
        if (z !== (ep == 32'd0)) begin
            failures++;
            $display("FAIL %s zero a=%h b=%h got %b want %b", tag, ja, jb, z, ep == 32'd0);
        end
        checks++;
        if (b1 !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_accept got %b want 1", tag, b1);
        end
        checks++;
        if (after !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after_done got %b want 0", tag, after);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (product !== 32'd0) begin failures++; $display("FAIL reset_product got %h want 0", product); end
        checks++;
        if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got %b want 1", zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        check_job("basic", 32'd1, 32'd28);
        check_job("signed_wrap", 32'hFFFF_FFFD, 32'd7);
        check_job("worst_case", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_job("zero_mplier", 32'd5, 32'd0);
        check_job("after_zero", 32'd6, 32'd2);
        check_job("zero_mcand", 32'd0, 32'h0000_0F00);
        check_job("top_bit", 32'h1234_5679, 32'h8000_0000);
    endtask

    task automatic test_random;
        logic [31:0] ra, rb;
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 32);
            if (i % 8 == 3) rb = 32'd0;
            check_job("random", ra, rb);
        end
    endtask

    task automatic test_start_busy;
        int ndone;
        int edges;
        a = 32'd3;
        b = 32'd4;
        start = 1'b1;
        @(negedge clk);
        a = 32'd9;
        b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        edges = 2;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        ndone = done ? 1 : 0;
        checks++;
        if (edges !== 4) begin failures++; $display("FAIL busy_start latency got %0d want 4", edges); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_start idle got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL busy_start second_job cycle %0d busy got %b want 0", i, busy);
            end
        end
        checks++;
        if (ndone !== 1) begin failures++; $display("FAIL busy_start done_pulses got %0d want 1", ndone); end
        checks++;
        if (product !== 32'd12) begin failures++; $display("FAIL busy_start product got %h want c", product); end
    endtask

    task automatic test_reset_mid;
        int ndone;
        a = 32'h0000_1234;
        b = 32'h8000_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got %b want 0", done); end
        checks++;
        if (product !== 32'd0) begin failures++; $display("FAIL midrst_product got %h want 0", product); end
        checks++;
        if (zero !== 1'b1) begin failures++; $display("FAIL midrst_zero got %b want 1", zero); end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin failures++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
        check_job("after_reset", 32'd2, 32'd3);
    endtask

    task automatic test_back_to_back;
        int          edges;
        logic [31:0] a2, b2;
        a2 = $urandom;
        b2 = ($urandom >> $urandom_range(0, 30)) | 32'd1;
        a = 32'd7;
        b = 32'd5;
        start = 1'b1;
        @(negedge clk);
        edges = 1;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        if (product !== 32'd35) begin failures++; $display("FAIL b2b first_product got %h want 23", product); end
        a = a2;
        b = b2;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b idle_gap busy got %b want 0", busy); end
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b second_accept busy got %b want 1", busy); end
        edges = 1;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges !== nbits(b2) + 1) begin
            failures++;
            $display("FAIL b2b second_latency got %0d want %0d", edges, nbits(b2) + 1);
        end
        checks++;
        if (product !== ref_mul(a2, b2)) begin
            failures++;
            $display("FAIL b2b second_product got %h want %h", product, ref_mul(a2, b2));
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
